// File: rtl/clk_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_gate_pkg
// Purpose  : Shared types and constants for the clock-gate controller.
// Revision : 1.0 - initial release
// ============================================================================
package clk_gate_pkg;

    // Width of the saturating gate-off event counter
    localparam int GATE_CNT_W = 16;

    // Controller states; the encoding is visible on the gate_state port
    typedef enum logic [1:0] {
        ST_ON   = 2'd0,
        ST_IDLE = 2'd1,
        ST_OFF  = 2'd2,
        ST_WAKE = 2'd3
    } gate_state_e;

endpackage
`default_nettype wire

// File: rtl/clk_gate_idle_timer.sv
`default_nettype none
// ============================================================================
// Module   : clk_gate_idle_timer
// Purpose  : Loadable down counter with a zero flag. Load wins over
//            decrement; decrement stops at zero.
// Revision : 1.0 - initial release
// ============================================================================
module clk_gate_idle_timer #(
    parameter int W = 8
) (
    input  logic         clk_sys,
    input  logic         rstn,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load has priority, otherwise decrement toward zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register, cleared asynchronously
    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_gate_ctrl
// Purpose  : Always-on ICG enable controller. Arbitrates clock demand from
//            NUM_REQ requesters, gates off after an idle hysteresis, and
//            re-enables with a fixed settle delay before acknowledging.
// Revision : 1.0 - initial release
// ============================================================================
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int IDLE_CNT_W = 8,
    parameter int WAKE_DLY   = 2
) (
    input  logic                  clk_sys,
    input  logic                  rstn,
    input  logic                  scan_en,
    input  logic                  cfg_gate_en,
    input  logic                  cfg_force_on,
    input  logic [IDLE_CNT_W-1:0] cfg_idle_thr,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    busy,
    output logic [NUM_REQ-1:0]    ack,
    output logic                  icg_enable,
    output gate_state_e           gate_state,
    output logic [GATE_CNT_W-1:0] gate_off_cnt
);

    // Wake timer counts WAKE_DLY-1 down to 0, giving WAKE_DLY cycles in WAKE
    localparam int                WAKE_W    = $clog2(WAKE_DLY + 1);
    localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_DLY - 1);

    gate_state_e           state_q;
    gate_state_e           state_d;
    logic                  icg_en_q;
    logic                  icg_en_d;
    logic [NUM_REQ-1:0]    ack_q;
    logic [NUM_REQ-1:0]    ack_d;
    logic [GATE_CNT_W-1:0] gate_off_cnt_q;
    logic [GATE_CNT_W-1:0] gate_off_cnt_d;

    logic keep_on;
    logic demand;
    logic idle_load;
    logic idle_dec;
    logic idle_zero;
    logic wake_load;
    logic wake_dec;
    logic wake_zero;
    logic gate_off_evt;

    assign keep_on = cfg_force_on | scan_en | ~cfg_gate_en;
    assign demand  = (|req) | (|busy);

    clk_gate_idle_timer #(
        .W (IDLE_CNT_W)
    ) u_idle_timer (
        .clk_sys    (clk_sys),
        .rstn       (rstn),
        .load_i     (idle_load),
        .load_val_i (cfg_idle_thr),
        .dec_i      (idle_dec),
        .zero_o     (idle_zero)
    );

    clk_gate_idle_timer #(
        .W (WAKE_W)
    ) u_wake_timer (
        .clk_sys    (clk_sys),
        .rstn       (rstn),
        .load_i     (wake_load),
        .load_val_i (WAKE_LOAD),
        .dec_i      (wake_dec),
        .zero_o     (wake_zero)
    );

    // Next-state and timer control; a wake-up request in IDLE beats expiry
    always_comb begin
        state_d      = state_q;
        idle_load    = 1'b0;
        idle_dec     = 1'b0;
        wake_load    = 1'b0;
        wake_dec     = 1'b0;
        gate_off_evt = 1'b0;
        case (state_q)
            ST_ON: begin
                if (!keep_on && !demand) begin
                    state_d   = ST_IDLE;
                    idle_load = 1'b1;
                end
            end
            ST_IDLE: begin
                idle_dec = 1'b1;
                if (keep_on || demand) begin
                    state_d = ST_ON;
                end else if (idle_zero) begin
                    state_d      = ST_OFF;
                    gate_off_evt = 1'b1;
                end
            end
            ST_OFF: begin
                if (keep_on || demand) begin
                    state_d   = ST_WAKE;
                    wake_load = 1'b1;
                end
            end
            ST_WAKE: begin
                // Inputs are deliberately ignored until the clock has settled
                wake_dec = 1'b1;
                if (wake_zero) begin
                    state_d = ST_ON;
                end
            end
            default: begin
                state_d = ST_ON;
            end
        endcase
    end

    // Registered outputs: enable follows next state, ack only from a settled ON
    always_comb begin
        icg_en_d       = (state_d != ST_OFF);
        ack_d          = req & {NUM_REQ{state_q == ST_ON}};
        gate_off_cnt_d = gate_off_cnt_q;
        if (gate_off_evt && (gate_off_cnt_q != {GATE_CNT_W{1'b1}})) begin
            gate_off_cnt_d = gate_off_cnt_q + GATE_CNT_W'(1);
        end
    end

    // State and output registers; reset returns to clock-on immediately
    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_ON;
            icg_en_q       <= 1'b1;
            ack_q          <= '0;
            gate_off_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            icg_en_q       <= icg_en_d;
            ack_q          <= ack_d;
            gate_off_cnt_q <= gate_off_cnt_d;
        end
    end

    assign ack          = ack_q;
    assign icg_enable   = icg_en_q;
    assign gate_state   = state_q;
    assign gate_off_cnt = gate_off_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_gate_ctrl
// Purpose  : Directed self-checking bench for clk_gate_ctrl (WAKE_DLY=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_gate_ctrl;
    import clk_gate_pkg::*;

    logic        clk_sys;
    logic        rstn;
    logic        scan_en;
    logic        cfg_gate_en;
    logic        cfg_force_on;
    logic [7:0]  cfg_idle_thr;
    logic [3:0]  req;
    logic [3:0]  busy;
    logic [3:0]  ack;
    logic        icg_enable;
    gate_state_e gate_state;
    logic [15:0] gate_off_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        gate_state_e st;
        logic        icg;
        logic [3:0]  ack;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    clk_gate_ctrl #(
        .NUM_REQ    (4),
        .IDLE_CNT_W (8),
        .WAKE_DLY   (2)
    ) dut (
        .clk_sys      (clk_sys),
        .rstn         (rstn),
        .scan_en      (scan_en),
        .cfg_gate_en  (cfg_gate_en),
        .cfg_force_on (cfg_force_on),
        .cfg_idle_thr (cfg_idle_thr),
        .req          (req),
        .busy         (busy),
        .ack          (ack),
        .icg_enable   (icg_enable),
        .gate_state   (gate_state),
        .gate_off_cnt (gate_off_cnt)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Queue an expectation for the next observation point
    task automatic push_exp(input string tag, input gate_state_e st, input logic icg,
                            input logic [3:0] a, input logic [15:0] c);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.icg = icg;
        e.ack = a;
        e.cnt = c;
        sb_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare all observable outputs
    task automatic check_out();
        exp_t e;
        e = sb_q.pop_front();
        n_tests++;
        assert (gate_state === e.st) else begin
            n_fail++;
            $error("FAIL %s state obs=%0d exp=%0d", e.tag, gate_state, e.st);
        end
        n_tests++;
        assert (icg_enable === e.icg) else begin
            n_fail++;
            $error("FAIL %s icg_enable obs=%b exp=%b", e.tag, icg_enable, e.icg);
        end
        n_tests++;
        assert (ack === e.ack) else begin
            n_fail++;
            $error("FAIL %s ack obs=%b exp=%b", e.tag, ack, e.ack);
        end
        n_tests++;
        assert (gate_off_cnt === e.cnt) else begin
            n_fail++;
            $error("FAIL %s gate_off_cnt obs=%h exp=%h", e.tag, gate_off_cnt, e.cnt);
        end
    endtask

    // One clock edge, then check the registered outputs 1 ns later
    task automatic step(input string tag, input gate_state_e st, input logic icg,
                        input logic [3:0] a, input logic [15:0] c);
        push_exp(tag, st, icg, a, c);
        @(posedge clk_sys);
        #1;
        check_out();
    endtask

    // Check without a clock edge (asynchronous reset response)
    task automatic check_now(input string tag, input gate_state_e st, input logic icg,
                             input logic [3:0] a, input logic [15:0] c);
        push_exp(tag, st, icg, a, c);
        check_out();
    endtask

    // From ON with no demand: thr+1 IDLE cycles, then OFF with count+1
    task automatic run_to_off(input string tag, input int thr, input logic [15:0] c);
        for (int i = 0; i <= thr; i++) begin
            step({tag, "_idle"}, ST_IDLE, 1'b1, 4'b0000, c);
        end
        step({tag, "_off"}, ST_OFF, 1'b0, 4'b0000, c + 16'd1);
    endtask

    initial begin
        rstn         = 1'b0;
        scan_en      = 1'b0;
        cfg_gate_en  = 1'b0;
        cfg_force_on = 1'b0;
        cfg_idle_thr = 8'd4;
        req          = 4'b0000;
        busy         = 4'b0000;

        // Reset values
        repeat (2) @(posedge clk_sys);
        #1;
        check_now("reset", ST_ON, 1'b1, 4'b0000, 16'd0);
        rstn        = 1'b1;
        cfg_gate_en = 1'b1;

        // Idle gate-off with thr=4
        run_to_off("t1", 4, 16'd0);

        // Wake via req[2], ack after settle, drop req
        req = 4'b0100;
        step("t2_wake0", ST_WAKE, 1'b1, 4'b0000, 16'd1);
        step("t2_wake1", ST_WAKE, 1'b1, 4'b0000, 16'd1);
        step("t2_on",    ST_ON,   1'b1, 4'b0000, 16'd1);
        step("t2_ack",   ST_ON,   1'b1, 4'b0100, 16'd1);
        req = 4'b0000;
        run_to_off("t2_fall", 4, 16'd1);

        // busy rising exactly at IDLE expiry wins over gate-off
        busy = 4'b0001;
        step("t3_wake0", ST_WAKE, 1'b1, 4'b0000, 16'd2);
        step("t3_wake1", ST_WAKE, 1'b1, 4'b0000, 16'd2);
        step("t3_on",    ST_ON,   1'b1, 4'b0000, 16'd2);
        busy = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step("t3_idle", ST_IDLE, 1'b1, 4'b0000, 16'd2);
        end
        busy = 4'b0001;
        step("t3_race", ST_ON, 1'b1, 4'b0000, 16'd2);
        busy = 4'b0000;
        run_to_off("t3", 4, 16'd2);

        // cfg_force_on in OFF: wake and stay on
        cfg_force_on = 1'b1;
        step("t4f_wake0", ST_WAKE, 1'b1, 4'b0000, 16'd3);
        step("t4f_wake1", ST_WAKE, 1'b1, 4'b0000, 16'd3);
        for (int i = 0; i < 8; i++) begin
            step("t4f_on", ST_ON, 1'b1, 4'b0000, 16'd3);
        end
        cfg_force_on = 1'b0;
        run_to_off("t4f", 4, 16'd3);

        // scan_en pulse: WAKE runs its full length even after scan_en drops
        scan_en = 1'b1;
        step("t4s_wake0", ST_WAKE, 1'b1, 4'b0000, 16'd4);
        scan_en = 1'b0;
        step("t4s_wake1", ST_WAKE, 1'b1, 4'b0000, 16'd4);
        step("t4s_on",    ST_ON,   1'b1, 4'b0000, 16'd4);
        run_to_off("t4s", 4, 16'd4);

        // cfg_gate_en=0 behaves as keep-on
        cfg_gate_en = 1'b0;
        step("t4g_wake0", ST_WAKE, 1'b1, 4'b0000, 16'd5);
        step("t4g_wake1", ST_WAKE, 1'b1, 4'b0000, 16'd5);
        for (int i = 0; i < 8; i++) begin
            step("t4g_on", ST_ON, 1'b1, 4'b0000, 16'd5);
        end
        cfg_gate_en = 1'b1;
        run_to_off("t4g", 4, 16'd5);

        // Asynchronous reset during WAKE
        req = 4'b0010;
        step("t5_wake", ST_WAKE, 1'b1, 4'b0000, 16'd6);
        #2;
        rstn = 1'b0;
        #1;
        check_now("t5_rst_wake", ST_ON, 1'b1, 4'b0000, 16'd0);
        req  = 4'b0000;
        rstn = 1'b1;
        run_to_off("t5", 4, 16'd0);

        // Asynchronous reset during OFF
        #2;
        rstn = 1'b0;
        #1;
        check_now("t5_rst_off", ST_ON, 1'b1, 4'b0000, 16'd0);
        rstn = 1'b1;

        // Saturation of the gate-off counter, with thr=0 (one IDLE cycle)
        cfg_gate_en = 1'b0;
        step("t6_hold", ST_ON, 1'b1, 4'b0000, 16'd0);
        force dut.gate_off_cnt_q = 16'hFFFE;
        step("t6_force", ST_ON, 1'b1, 4'b0000, 16'hFFFE);
        release dut.gate_off_cnt_q;
        step("t6_rel", ST_ON, 1'b1, 4'b0000, 16'hFFFE);
        cfg_idle_thr = 8'd0;
        cfg_gate_en  = 1'b1;
        step("t6_idle", ST_IDLE, 1'b1, 4'b0000, 16'hFFFE);
        step("t6_off",  ST_OFF,  1'b0, 4'b0000, 16'hFFFF);
        for (int i = 0; i < 2; i++) begin
            busy = 4'b1000;
            step("t6s_wake0", ST_WAKE, 1'b1, 4'b0000, 16'hFFFF);
            busy = 4'b0000;
            step("t6s_wake1", ST_WAKE, 1'b1, 4'b0000, 16'hFFFF);
            step("t6s_on",    ST_ON,   1'b1, 4'b0000, 16'hFFFF);
            step("t6s_idle",  ST_IDLE, 1'b1, 4'b0000, 16'hFFFF);
            step("t6s_off",   ST_OFF,  1'b0, 4'b0000, 16'hFFFF);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog timeout obs=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
